alu_muldiv: RTL and testbench

//  Iterative RV M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, one radix-2 step per cycle.

---
 rtl/alu_muldiv_if.sv | 28 ++
 rtl/alu_muldiv.sv | 151 +++++++++++++++
 tb/tb_alu_muldiv.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master is the pipeline side; the slave is alu_muldiv.
interface alu_muldiv_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic            s_32;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd;
    logic            zero;
    logic            busy;

    modport master (
        output flush, in_valid, op, s_32, rs1, rs2, out_ready,
        input  in_ready, out_valid, rd, zero, busy
    );

    modport slave (
        input  flush, in_valid, op, s_32, rs1, rs2, out_ready,
        output in_ready, out_valid, rd, zero, busy
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV M-extension unit: shift-add multiply and restoring divide,
// one radix-2 step per cycle on operand magnitudes, signs fixed up at the end.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst,
    alu_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic              s32_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplr_q;
    logic [XLEN-1:0]   rd_q;

    logic [XLEN-1:0]   w_mask, min_w, a_val, b_val, a_mag, b_mag, a_sext, spec_res;
    logic              signed_a, signed_b, sa, sb, div_zero, div_ovf, special;
    logic [2*XLEN-1:0] acc_step, prod_fix;
    logic [XLEN:0]     rem_sh, rem_sub;
    logic [XLEN-1:0]   qr_sel, qr_fix, final_res;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Operand conditioning at accept: width select, magnitudes and the
    // divide-by-zero / MIN/-1 shortcuts that skip the iteration entirely.
    always_comb begin
        w_mask   = bus.s_32 ? XLEN'(32'hFFFF_FFFF) : '1;
        min_w    = bus.s_32 ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        a_val    = bus.rs1 & w_mask;
        b_val    = bus.rs2 & w_mask;
        signed_a = bus.op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
        signed_b = bus.op inside {3'd0, 3'd1, 3'd4, 3'd6};
        sa       = signed_a && (bus.s_32 ? bus.rs1[31] : bus.rs1[XLEN-1]);
        sb       = signed_b && (bus.s_32 ? bus.rs2[31] : bus.rs2[XLEN-1]);
        a_mag    = sa ? ((-a_val) & w_mask) : a_val;
        b_mag    = sb ? ((-b_val) & w_mask) : b_val;
        a_sext   = bus.s_32 ? sext32(a_val[31:0]) : a_val;
        div_zero = bus.op[2] && (b_val == '0);
        div_ovf  = bus.op[2] && !bus.op[0] && (a_val == min_w) && (b_val == w_mask);
        special  = div_zero || div_ovf;
        spec_res = '0;
        if (div_zero) begin
            spec_res = bus.op[1] ? a_sext : '1;
        end else if (div_ovf) begin
            spec_res = bus.op[1] ? '0 : (bus.s_32 ? sext32(32'h8000_0000) : min_w);
        end
    end

    // One iteration step plus the sign fix-up and result selection that
    // are applied to the final step's value on the way into DONE.
    always_comb begin
        rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_sub = rem_sh - {1'b0, mplr_q};
        if (op_q[2]) begin
            if (rem_sh >= {1'b0, mplr_q}) begin
                acc_step = {rem_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
        end
        prod_fix = neg_q ? -acc_step : acc_step;
        qr_sel   = op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        qr_fix   = neg_q ? -qr_sel : qr_sel;
        case (op_q)
            3'd0:    final_res = s32_q ? sext32(prod_fix[31:0]) : prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:
                     final_res = s32_q ? sext32(prod_fix[63:32]) : prod_fix[2*XLEN-1:XLEN];
            default: final_res = s32_q ? sext32(qr_fix[31:0]) : qr_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.in_valid) state_d = special ? DONE : CALC;
                CALC:    if (cnt_q == CW'(1)) state_d = DONE;
                DONE:    if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers; flush freezes them so a discarded op never lands in rd.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            s32_q   <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            rd_q    <= '0;
        end else if (!bus.flush) begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q   <= bus.op;
                        s32_q  <= bus.s_32;
                        cnt_q  <= bus.s_32 ? CW'(32) : CW'(XLEN);
                        mplr_q <= b_mag;
                        if (bus.op[2]) begin
                            acc_q   <= {{XLEN{1'b0}}, a_mag << (bus.s_32 ? XLEN - 32 : 0)};
                            mcand_q <= '0;
                            neg_q   <= bus.op[1] ? sa : (sa ^ sb);
                        end else begin
                            acc_q   <= '0;
                            mcand_q <= {{XLEN{1'b0}}, a_mag};
                            neg_q   <= sa ^ sb;
                        end
                        if (special) rd_q <= spec_res;
                    end
                end
                CALC: begin
                    acc_q   <= acc_step;
                    mcand_q <= mcand_q << 1;
                    mplr_q  <= op_q[2] ? mplr_q : (mplr_q >> 1);
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) rd_q <= final_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rd        = rd_q;
    assign bus.zero      = (rd_q == '0);
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: a 32-bit and a 64-bit instance share clock
// and reset; every result is compared against hand-computed constants.
module tb_alu_muldiv;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_muldiv_if #(.XLEN(32)) bus32 ();
    alu_muldiv_if #(.XLEN(64)) bus64 ();

    alu_muldiv #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    alu_muldiv #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble the operands after accept, wait (bounded) for out_valid.
    // lat counts the cycle index in which out_valid is seen, the accept edge being cycle 0->1.
    task automatic applyStimulus(input bit use64, input logic [2:0] op, input logic s32,
                                 input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] res, output int lat);
        if (use64) begin
            bus64.op = op; bus64.s_32 = s32; bus64.rs1 = a; bus64.rs2 = b; bus64.in_valid = 1'b1;
        end else begin
            bus32.op = op; bus32.s_32 = s32; bus32.rs1 = a[31:0]; bus32.rs2 = b[31:0];
            bus32.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        bus64.in_valid = 1'b0;
        bus32.rs1 = $urandom;
        bus64.rs1 = {$urandom, $urandom};
        lat = 1;
        while (!(use64 ? bus64.out_valid : bus32.out_valid) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("out_valid reached", use64 ? bus64.out_valid : bus32.out_valid, 64'd1);
        res = use64 ? bus64.rd : {32'h0, bus32.rd};
    endtask

    task automatic releaseResult();
        bus32.out_ready = 1'b1;
        bus64.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        bus64.out_ready = 1'b0;
    endtask

    task automatic runOp(input string tag, input bit use64, input logic [2:0] op, input logic s32,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat);
        logic [63:0] res;
        int          lat;
        applyStimulus(use64, op, s32, a, b, res, lat);
        checkOutput(tag, res, exp);
        if (exp_lat >= 0) checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
        releaseResult();
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        bit          seen;

        rst = 1'b1;
        bus32.flush = 0; bus32.in_valid = 0; bus32.out_ready = 0;
        bus32.op = 0; bus32.s_32 = 0; bus32.rs1 = 0; bus32.rs2 = 0;
        bus64.flush = 0; bus64.in_valid = 0; bus64.out_ready = 0;
        bus64.op = 0; bus64.s_32 = 0; bus64.rs1 = 0; bus64.rs2 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("reset in_ready", bus32.in_ready, 64'd1);
        checkOutput("reset out_valid", bus32.out_valid, 64'd0);
        checkOutput("reset busy", bus32.busy, 64'd0);
        checkOutput("reset rd", bus32.rd, 64'd0);
        checkOutput("reset zero", bus32.zero, 64'd1);

        runOp("mul 7*-3", 0, 3'd0, 0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 33);
        runOp("mulhu max*max", 0, 3'd3, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 33);
        runOp("mulh min*min", 0, 3'd1, 0, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, -1);
        runOp("mulhsu -1*max", 0, 3'd2, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, -1);
        runOp("div -7/2", 0, 3'd4, 0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 33);
        runOp("rem -7/2", 0, 3'd6, 0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, -1);
        runOp("divu 5/0", 0, 3'd5, 0, 64'd5, 64'd0, 64'hFFFF_FFFF, 1);
        runOp("remu 5/0", 0, 3'd7, 0, 64'd5, 64'd0, 64'd5, 1);
        runOp("div min/-1", 0, 3'd4, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1);

        applyStimulus(0, 3'd6, 0, 64'h8000_0000, 64'hFFFF_FFFF, res, lat);
        checkOutput("rem min/-1", res, 64'd0);
        checkOutput("rem min/-1 zero", bus32.zero, 64'd1);
        releaseResult();

        runOp("w div ovf", 1, 3'd4, 1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, -1);
        runOp("w mul", 1, 3'd0, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        runOp("w remu", 1, 3'd7, 1, 64'hDEAD_BEEF_0000_000B, 64'h1234_0000_0003, 64'd2, 33);
        runOp("d mulhu", 1, 3'd3, 0, '1, 64'd2, 64'd1, 65);
        runOp("d div -100/7", 1, 3'd4, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
              64'hFFFF_FFFF_FFFF_FFF2, 65);
        runOp("d rem -100/7", 1, 3'd6, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
              64'hFFFF_FFFF_FFFF_FFFE, -1);

        // Backpressure: result must stay put and a pending request must be ignored.
        applyStimulus(0, 3'd0, 0, 64'd6, 64'd7, res, lat);
        checkOutput("bp mul", res, 64'd42);
        bus32.in_valid = 1'b1; bus32.op = 3'd5; bus32.rs1 = 9; bus32.rs2 = 3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp rd held", bus32.rd, 64'd42);
            checkOutput("bp in_ready", bus32.in_ready, 64'd0);
            checkOutput("bp out_valid", bus32.out_valid, 64'd1);
        end
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        bus32.in_valid = 1'b0;
        checkOutput("bp released in_ready", bus32.in_ready, 64'd1);
        checkOutput("bp released out_valid", bus32.out_valid, 64'd0);

        // Flush mid-calculation.
        bus32.op = 3'd0; bus32.s_32 = 0; bus32.rs1 = 3; bus32.rs2 = 5; bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus32.flush = 1'b1;
        @(posedge clk); #1;
        bus32.flush = 1'b0;
        checkOutput("flush in_ready", bus32.in_ready, 64'd1);
        checkOutput("flush busy", bus32.busy, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus32.out_valid) seen = 1'b1;
        end
        checkOutput("flush no out_valid", 64'(seen), 64'd0);
        runOp("post-flush divu 100/7", 0, 3'd5, 0, 64'd100, 64'd7, 64'd14, 33);
        runOp("post-flush remu 100/7", 0, 3'd7, 0, 64'd100, 64'd7, 64'd2, 33);

        // Reset mid-calculation also clears rd.
        bus32.op = 3'd0; bus32.rs1 = 3; bus32.rs2 = 5; bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst rd", bus32.rd, 64'd0);
        checkOutput("rst zero", bus32.zero, 64'd1);
        checkOutput("rst in_ready", bus32.in_ready, 64'd1);
        checkOutput("rst out_valid", bus32.out_valid, 64'd0);
        runOp("post-rst mul 3*5", 0, 3'd0, 0, 64'd3, 64'd5, 64'd15, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
